// File: rtl/awg_cpu_pkg.sv
// Shared types and constants for the AWG sequencer instruction-fetch front end.
package awg_cpu_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOOKUP,
    ST_COMPARE,
    ST_AR,
    ST_R,
    ST_OUT
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_MODE = 4'b0011;
  localparam logic [2:0] AXI_SIZE_16B   = 3'b100;

  localparam logic [3:0] END_OPCODE = 4'hF;

  // pc = {tag, index, word select, byte offset}
  localparam int unsigned WSEL_LSB = 2;
  localparam int unsigned IDX_LSB  = 4;

endpackage

// File: rtl/awg_sp_ram.sv
// Generic synchronous single-port RAM, one-cycle read latency.
module awg_sp_ram #(
  parameter int unsigned dw = 32,
  parameter int unsigned aw = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [aw-1:0] addr,
  input  logic [dw-1:0] wdata,
  output logic [dw-1:0] rdata
);

  logic [dw-1:0] mem [0:(1<<aw)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/awg_cpu_top.sv
// Instruction fetch for the AWG sequencer: direct-mapped line cache filled over
// single-beat AXI4 reads, instruction words streamed out on an AXI-Stream port.
module awg_cpu_top
  import awg_cpu_pkg::*;
#(
  parameter int unsigned tag_dw = 20,
  parameter int unsigned tag_aw = 9,
  parameter int unsigned ram_dw = 128,
  parameter int unsigned ram_aw = 9,
  parameter int unsigned C_M0_AXI_READ_BURST_LEN    = 1,
  parameter int unsigned C_M0_AXI_READ_ID_WIDTH     = 4,
  parameter int unsigned C_M0_AXI_READ_ADDR_WIDTH   = 32,
  parameter int unsigned C_M0_AXI_READ_DATA_WIDTH   = 128,
  parameter int unsigned C_M0_AXI_READ_ARUSER_WIDTH = 0,
  parameter int unsigned C_M0_AXI_READ_RUSER_WIDTH  = 0,
  parameter logic [C_M0_AXI_READ_ADDR_WIDTH-1:0] C_M0_AXI_READ_TARGET_SLAVE_BASE_ADDR = '0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                stop,
  input  logic                                instr_mem_s_axi_arready,
  output logic [C_M0_AXI_READ_ADDR_WIDTH-1:0] instr_mem_s_axi_araddr,
  output logic [1:0]                          instr_mem_s_axi_arburst,
  output logic [3:0]                          instr_mem_s_axi_arcache,
  output logic [C_M0_AXI_READ_ID_WIDTH-1:0]   instr_mem_s_axi_arid,
  output logic [7:0]                          instr_mem_s_axi_arlen,
  output logic                                instr_mem_s_axi_arlock,
  output logic [2:0]                          instr_mem_s_axi_arprot,
  output logic [3:0]                          instr_mem_s_axi_arqos,
  output logic [2:0]                          instr_mem_s_axi_arsize,
  output logic                                instr_mem_s_axi_arvalid,
  input  logic [C_M0_AXI_READ_ID_WIDTH-1:0]   instr_mem_s_axi_rid,
  input  logic [C_M0_AXI_READ_DATA_WIDTH-1:0] instr_mem_s_axi_rdata,
  input  logic                                instr_mem_s_axi_rlast,
  input  logic [1:0]                          instr_mem_s_axi_rresp,
  input  logic                                instr_mem_s_axi_rvalid,
  output logic                                instr_mem_s_axi_rready,
  input  logic                                axis_ready,
  output logic [31:0]                         axis_data,
  output logic                                axis_valid,
  output logic                                axis_last
);

  localparam int unsigned TW = tag_dw - 1;

  state_t               state, state_nx;
  logic [31:0]          pc;
  logic [31:0]          data_q;
  logic [tag_aw-1:0]    init_cnt;
  logic                 start_q, start_pend, stop_req;
  logic                 tag_we, data_we;
  logic [tag_aw-1:0]    tag_addr;
  logic [tag_dw-1:0]    tag_wdata, tag_rdata;
  logic [ram_dw-1:0]    data_rdata;
  logic [ram_aw-1:0]    idx;
  logic [TW-1:0]        cur_tag;
  logic [31:0]          sel_word;
  logic                 start_edge, stop_any, hit, is_end, rd_ok;
  logic                 unused_ok;

  assign idx        = pc[IDX_LSB +: ram_aw];
  assign cur_tag    = pc[31 -: TW];
  assign sel_word   = data_rdata[{pc[WSEL_LSB +: 2], 5'd0} +: 32];
  assign start_edge = start & ~start_q;
  assign stop_any   = stop | stop_req;
  assign hit        = tag_rdata[tag_dw-1] && (tag_rdata[TW-1:0] == cur_tag);
  assign is_end     = (data_q[31:28] == END_OPCODE);
  assign rd_ok      = (instr_mem_s_axi_rresp == 2'b00);
  assign unused_ok  = ^{instr_mem_s_axi_rid, instr_mem_s_axi_rlast};

  assign tag_addr  = (state == ST_INIT) ? init_cnt : idx;
  assign tag_wdata = (state == ST_INIT) ? '0 : {1'b1, cur_tag};

  awg_sp_ram #(.dw(tag_dw), .aw(tag_aw)) u_tag_ram (
    .clk   (clk),
    .we    (tag_we),
    .addr  (tag_addr),
    .wdata (tag_wdata),
    .rdata (tag_rdata)
  );

  awg_sp_ram #(.dw(ram_dw), .aw(ram_aw)) u_data_ram (
    .clk   (clk),
    .we    (data_we),
    .addr  (idx),
    .wdata (instr_mem_s_axi_rdata),
    .rdata (data_rdata)
  );

  always_comb begin
    state_nx = state;
    tag_we   = 1'b0;
    data_we  = 1'b0;
    case (state)
      ST_INIT: begin
        tag_we = 1'b1;
        if (init_cnt == '1) state_nx = ST_IDLE;
      end
      ST_IDLE:    if (!stop && (start_edge || start_pend)) state_nx = ST_LOOKUP;
      ST_LOOKUP:  state_nx = stop_any ? ST_IDLE : ST_COMPARE;
      ST_COMPARE: state_nx = stop_any ? ST_IDLE : (hit ? ST_OUT : ST_AR);
      ST_AR:      if (instr_mem_s_axi_arready) state_nx = ST_R;
      ST_R: begin
        // The beat is always accepted; a stop only diverts the return path.
        if (instr_mem_s_axi_rvalid) begin
          tag_we   = rd_ok;
          data_we  = rd_ok;
          state_nx = (rd_ok && !stop_any) ? ST_LOOKUP : ST_IDLE;
        end
      end
      ST_OUT:     if (axis_ready) state_nx = (is_end || stop_any) ? ST_IDLE : ST_LOOKUP;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      pc         <= '0;
      data_q     <= '0;
      init_cnt   <= '0;
      start_q    <= 1'b0;
      start_pend <= 1'b0;
      stop_req   <= 1'b0;
    end else begin
      state   <= state_nx;
      start_q <= start;
      if (state == ST_INIT) init_cnt <= init_cnt + tag_aw'(1);
      if (state == ST_INIT)      start_pend <= start_pend | start_edge;
      else if (state == ST_IDLE) start_pend <= 1'b0;
      stop_req <= (state == ST_IDLE || state == ST_INIT) ? 1'b0 : (stop_req | stop);
      if (state == ST_IDLE && state_nx == ST_LOOKUP) pc <= '0;
      if (state == ST_OUT && state_nx == ST_LOOKUP)  pc <= pc + 32'd4;
      if (state == ST_COMPARE && state_nx == ST_OUT) data_q <= sel_word;
    end
  end

  assign instr_mem_s_axi_araddr  = (state == ST_AR)
      ? C_M0_AXI_READ_TARGET_SLAVE_BASE_ADDR + C_M0_AXI_READ_ADDR_WIDTH'({pc[31:4], 4'b0})
      : '0;
  assign instr_mem_s_axi_arvalid = (state == ST_AR);
  assign instr_mem_s_axi_rready  = (state == ST_R);
  assign instr_mem_s_axi_arburst = AXI_BURST_INCR;
  assign instr_mem_s_axi_arcache = AXI_CACHE_MODE;
  assign instr_mem_s_axi_arid    = '0;
  assign instr_mem_s_axi_arlen   = 8'(C_M0_AXI_READ_BURST_LEN - 1);
  assign instr_mem_s_axi_arlock  = 1'b0;
  assign instr_mem_s_axi_arprot  = '0;
  assign instr_mem_s_axi_arqos   = '0;
  assign instr_mem_s_axi_arsize  = AXI_SIZE_16B;

  assign axis_data  = data_q;
  assign axis_valid = (state == ST_OUT);
  assign axis_last  = (state == ST_OUT) && is_end;

endmodule

// File: tb/tb_awg_cpu_top.sv
// Directed self-checking bench for awg_cpu_top with a single-beat AXI read slave model.
module tb_awg_cpu_top;

  logic         clk = 1'b0;
  logic         rst_n, start, stop;
  logic         arready, arvalid, arlock, rlast, rvalid, rready;
  logic [31:0]  araddr;
  logic [1:0]   arburst, rresp;
  logic [3:0]   arcache, arid, arqos, rid;
  logic [7:0]   arlen;
  logic [2:0]   arprot, arsize;
  logic [127:0] rdata;
  logic         axis_ready, axis_valid, axis_last;
  logic [31:0]  axis_data;

  int tests = 0;
  int fails = 0;

  int          img = 0;
  int          r_delay = 1;
  logic [1:0]  rresp_val = 2'b00;
  logic [31:0] ar_log[$];
  logic [31:0] sl_addr;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } vec_t;
  vec_t va[5];

  always #5 clk = ~clk;

  awg_cpu_top dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .start                   (start),
    .stop                    (stop),
    .instr_mem_s_axi_arready (arready),
    .instr_mem_s_axi_araddr  (araddr),
    .instr_mem_s_axi_arburst (arburst),
    .instr_mem_s_axi_arcache (arcache),
    .instr_mem_s_axi_arid    (arid),
    .instr_mem_s_axi_arlen   (arlen),
    .instr_mem_s_axi_arlock  (arlock),
    .instr_mem_s_axi_arprot  (arprot),
    .instr_mem_s_axi_arqos   (arqos),
    .instr_mem_s_axi_arsize  (arsize),
    .instr_mem_s_axi_arvalid (arvalid),
    .instr_mem_s_axi_rid     (rid),
    .instr_mem_s_axi_rdata   (rdata),
    .instr_mem_s_axi_rlast   (rlast),
    .instr_mem_s_axi_rresp   (rresp),
    .instr_mem_s_axi_rvalid  (rvalid),
    .instr_mem_s_axi_rready  (rready),
    .axis_ready              (axis_ready),
    .axis_data               (axis_data),
    .axis_valid              (axis_valid),
    .axis_last               (axis_last)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (img == 0) begin
      case (a)
        32'h0:   return 32'h11111111;
        32'h4:   return 32'h22222222;
        32'h8:   return 32'h33333333;
        32'hC:   return 32'h44444444;
        32'h10:  return 32'hF0000000;
        default: return 32'h0;
      endcase
    end
    if (a == 32'h2000) return 32'hF0002000;
    return {4'hA, a[27:0]};
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    return {mem_word(a + 32'd12), mem_word(a + 32'd8), mem_word(a + 32'd4), mem_word(a)};
  endfunction

  // AXI read slave: arready after two wait cycles, single beat after r_delay cycles.
  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rid = '0; rlast = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (arvalid) begin
        sl_addr = araddr;
        ar_log.push_back(sl_addr);
        repeat (2) begin
          tick(1);
          chk("ar_hold_valid", arvalid, 1);
          chk("ar_hold_addr", araddr, sl_addr);
        end
        arready = 1'b1;
        tick(1);
        arready = 1'b0;
        repeat (r_delay) @(posedge clk);
        rdata = mem_line(sl_addr); rresp = rresp_val; rvalid = 1'b1; rlast = 1'b1;
        for (int k = 0; k < 50 && !rready; k++) tick(1);
        tick(1);
        rvalid = 1'b0; rlast = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; axis_ready = 1'b1;
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic recv(input string name, output logic [31:0] d, output logic l, output bit ok);
    int k;
    k = 0;
    while (!axis_valid && k < 60) begin tick(1); k++; end
    ok = axis_valid;
    chk({name, "_valid"}, axis_valid, 1);
    d = axis_data;
    l = axis_last;
    if (ok && axis_ready) tick(1);
  endtask

  task automatic quiet(input string name, input int n);
    int v;
    v = 0;
    for (int i = 0; i < n; i++) begin tick(1); if (axis_valid) v++; end
    chk(name, v, 0);
  endtask

  initial begin
    logic [31:0] d, e;
    logic        l;
    bit          ok;
    int          cnt, bad;

    va[0] = '{32'h11111111, 1'b0};
    va[1] = '{32'h22222222, 1'b0};
    va[2] = '{32'h33333333, 1'b0};
    va[3] = '{32'h44444444, 1'b0};
    va[4] = '{32'hF0000000, 1'b1};

    // Reset values and constant AXI fields
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; axis_ready = 1'b1;
    tick(2);
    chk("rst_axis_valid", axis_valid, 0);
    chk("rst_axis_data", axis_data, 0);
    chk("rst_axis_last", axis_last, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_rready", rready, 0);
    chk("c_arburst", arburst, 2'b01);
    chk("c_arcache", arcache, 4'b0011);
    chk("c_arsize", arsize, 3'b100);
    chk("c_arlen", arlen, 0);
    chk("c_arid", arid, 0);
    chk("c_arlock_prot_qos", {arlock, arprot, arqos}, 0);
    rst_n = 1'b1;
    tick(520);
    chk("init_axis_valid", axis_valid, 0);
    chk("init_axis_data", axis_data, 0);
    chk("init_arvalid", arvalid, 0);
    chk("init_rready", rready, 0);
    chk("init_ar_count", ar_log.size(), 0);

    // Start pulse during the tag sweep is honoured once the sweep ends
    do_reset();
    ar_log.delete();
    tick(50);
    pulse_start();
    cnt = 0;
    while (!arvalid && cnt < 700) begin tick(1); cnt++; end
    chk("init_start_ar_cycle", (cnt >= 450 && cnt <= 480), 1);
    for (int i = 0; i < 5; i++) begin
      recv($sformatf("cold_w%0d", i), d, l, ok);
      chk($sformatf("cold_data%0d", i), d, va[i].data);
      chk($sformatf("cold_last%0d", i), l, va[i].last);
    end
    quiet("cold_idle_after_end", 10);
    chk("cold_ar_count", ar_log.size(), 2);
    chk("cold_ar0", (ar_log.size() > 0) ? ar_log[0] : 32'hDEADBEEF, 32'h0);
    chk("cold_ar1", (ar_log.size() > 1) ? ar_log[1] : 32'hDEADBEEF, 32'h10);

    // Warm run: all hits, 3-cycle latency, then backpressure on the first word
    axis_ready = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("warm_lat1", axis_valid, 0);
    tick(1);
    chk("warm_lat2", axis_valid, 0);
    tick(1);
    chk("warm_lat3", axis_valid, 1);
    chk("warm_first", axis_data, 32'h11111111);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("bp_valid", axis_valid, 1);
      chk("bp_data", axis_data, 32'h11111111);
    end
    axis_ready = 1'b1;
    tick(1);
    for (int i = 1; i < 5; i++) begin
      recv($sformatf("warm_w%0d", i), d, l, ok);
      chk($sformatf("warm_data%0d", i), d, va[i].data);
      chk($sformatf("warm_last%0d", i), l, va[i].last);
    end
    chk("warm_no_ar", ar_log.size(), 2);

    // Conflict miss: walk up to 0x2000 (index 0, tag 1)
    do_reset();
    tick(520);
    img = 1;
    ar_log.delete();
    pulse_start();
    bad = 0;
    for (int i = 0; i < 2048; i++) begin
      recv("walk", d, l, ok);
      if (!ok) break;
      e = {4'hA, 28'(i * 4)};
      if (d !== e || l !== 1'b0) begin
        if (bad == 0) $display("note: walk first bad word %0d got %08h/%0b want %08h/0", i, d, l, e);
        bad++;
      end
    end
    chk("walk_bad_words", bad, 0);
    recv("walk_end", d, l, ok);
    chk("walk_end_data", d, 32'hF0002000);
    chk("walk_end_last", l, 1);
    chk("walk_ar_count", ar_log.size(), 513);
    chk("walk_ar_last", (ar_log.size() > 0) ? ar_log[ar_log.size() - 1] : 32'hDEADBEEF, 32'h2000);

    // Line 0 was evicted; also stop while holding a word in OUT
    ar_log.delete();
    axis_ready = 1'b0;
    pulse_start();
    recv("evict_w0", d, l, ok);
    chk("evict_data", d, 32'hA0000000);
    chk("evict_ar0", (ar_log.size() > 0) ? ar_log[0] : 32'hDEADBEEF, 32'h0);
    stop = 1'b1;
    tick(2);
    chk("stop_out_valid", axis_valid, 1);
    chk("stop_out_data", axis_data, 32'hA0000000);
    chk("stop_out_last", axis_last, 0);
    axis_ready = 1'b1;
    tick(1);
    stop = 1'b0;
    quiet("stop_out_idle", 20);
    chk("evict_ar_count", ar_log.size(), 1);

    // Error response on the fill, then stop during R
    do_reset();
    tick(520);
    img = 0;
    rresp_val = 2'b10;
    ar_log.delete();
    pulse_start();
    quiet("err_no_valid", 30);
    chk("err_ar_count", ar_log.size(), 1);
    rresp_val = 2'b00;
    r_delay = 6;
    ar_log.delete();
    pulse_start();
    cnt = 0;
    while (!rready && cnt < 40) begin tick(1); cnt++; end
    chk("stopR_rready", rready, 1);
    stop = 1'b1;
    tick(2);
    stop = 1'b0;
    quiet("stopR_no_valid", 30);
    chk("stopR_ar_count", ar_log.size(), 1);
    chk("stopR_rready_low", rready, 0);

    // The fill completed under stop must now hit
    r_delay = 1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("post_lat1", axis_valid, 0);
    tick(1);
    chk("post_lat2", axis_valid, 0);
    tick(1);
    chk("post_lat3", axis_valid, 1);
    chk("post_first", axis_data, 32'h11111111);
    tick(1);
    for (int i = 1; i < 5; i++) begin
      recv($sformatf("post_w%0d", i), d, l, ok);
      chk($sformatf("post_data%0d", i), d, va[i].data);
      chk($sformatf("post_last%0d", i), l, va[i].last);
    end
    chk("post_ar_count", ar_log.size(), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
